// File: rtl/am_modulator.sv
// -----------------------------------------------------------------------------
// am_modulator
//
// Turns a 16-bit signed audio stream into an AM envelope and rotates that
// envelope through a four-phase I/Q sequence (0, 90, 180, 270 degrees).
//
// Audio samples arrive on clkData, which is asynchronous to clk. Each rising
// edge of clkData produces exactly one I/Q output pair, four clk edges after
// clkData is first sampled high.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   clkData    in   audio sample strobe (async), one sample per rising edge
//   d_in       in   [15:0] signed audio sample, held while clkData is high
//   clip_clr   in   clears the sticky clip flag
//   I_out      out  [7:0] signed in-phase sample
//   Q_out      out  [7:0] signed quadrature sample
//   out_valid  out  one-cycle pulse marking a new I_out/Q_out pair
//   clip       out  sticky flag, set when an envelope had to be clamped
//
// Parameters
//   CARRIER    unmodulated envelope amplitude (0..127)
//   MOD_SHIFT  extra arithmetic right shift on the audio (0..7)
// -----------------------------------------------------------------------------
module am_modulator #(
  parameter int CARRIER   = 64,
  parameter int MOD_SHIFT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkData,
  input  logic [15:0] d_in,
  input  logic        clip_clr,
  output logic [7:0]  I_out,
  output logic [7:0]  Q_out,
  output logic        out_valid,
  output logic        clip
);

  localparam int SHIFT = 8 + MOD_SHIFT;

  // ---------------------------------------------------------------------------
  // clkData synchroniser and rising-edge detect
  // ---------------------------------------------------------------------------
  logic       sync1_q, sync2_q, sync3_q;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;
  logic       edge_det;

  // After reset the sync flops hold zeros that were never sampled from
  // clkData. A strobe that was already high would look like a fresh rising
  // edge, so detection stays disarmed until a genuine low has been seen
  // at sync2. fill_q counts edges until sync2 holds a real sample.
  always_comb begin
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    armed_d = armed_q | ((fill_q == 2'd2) & ~sync2_q);
  end

  assign edge_det = sync2_q & ~sync3_q & armed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      fill_q  <= 2'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= clkData;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: sample capture
  // ---------------------------------------------------------------------------
  logic        s1_valid_q, s1_valid_d;
  logic [15:0] s1_data_q, s1_data_d;

  always_comb begin
    s1_valid_d = edge_det;
    s1_data_d  = edge_det ? d_in : s1_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= 16'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: scale, add carrier, clamp to 0..127
  // ---------------------------------------------------------------------------
  logic signed [15:0] scaled;
  logic signed [16:0] env_full;
  logic               env_neg, env_over;
  logic [6:0]         env_sat;

  logic       s2_valid_q, s2_valid_d;
  logic [6:0] s2_env_q, s2_env_d;
  logic       s2_clamp_q, s2_clamp_d;

  always_comb begin
    scaled   = $signed(s1_data_q) >>> SHIFT;
    // 17 bits holds every CARRIER + scaled combination without wrapping.
    env_full = {scaled[15], scaled} + 17'(CARRIER);
    env_neg  = env_full[16];
    env_over = ~env_neg & (|env_full[15:7]);
    if (env_neg) begin
      env_sat = 7'd0;
    end else if (env_over) begin
      env_sat = 7'h7F;
    end else begin
      env_sat = env_full[6:0];
    end
  end

  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_env_d   = s1_valid_q ? env_sat : s2_env_q;
    s2_clamp_d = s1_valid_q & (env_neg | env_over);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_env_q   <= 7'd0;
      s2_clamp_q <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_env_q   <= s2_env_d;
      s2_clamp_q <= s2_clamp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: phase rotation, output registers and sticky clip
  // ---------------------------------------------------------------------------
  logic [1:0] phase_q, phase_d;
  logic [7:0] i_q, i_d;
  logic [7:0] q_q, q_d;
  logic       valid_q, valid_d;
  logic       clip_q, clip_d;
  logic [7:0] env8, env8_neg;

  always_comb begin
    env8     = {1'b0, s2_env_q};
    env8_neg = 8'd0 - env8;

    i_d      = i_q;
    q_d      = q_q;
    valid_d  = 1'b0;
    phase_d  = phase_q;

    if (s2_valid_q) begin
      valid_d = 1'b1;
      phase_d = phase_q + 2'd1;
      case (phase_q)
        2'd0: begin i_d = env8;     q_d = 8'd0;     end
        2'd1: begin i_d = 8'd0;     q_d = env8;     end
        2'd2: begin i_d = env8_neg; q_d = 8'd0;     end
        default: begin i_d = 8'd0;  q_d = env8_neg; end
      endcase
    end

    // A clip event on the same edge as clip_clr wins.
    if (s2_valid_q && s2_clamp_q) begin
      clip_d = 1'b1;
    end else if (clip_clr) begin
      clip_d = 1'b0;
    end else begin
      clip_d = clip_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 2'd0;
      i_q     <= 8'd0;
      q_q     <= 8'd0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      i_q     <= i_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
    end
  end

  assign I_out     = i_q;
  assign Q_out     = q_q;
  assign out_valid = valid_q;
  assign clip      = clip_q;

endmodule

// File: tb/tb_am_modulator.sv
// -----------------------------------------------------------------------------
// tb_am_modulator
//
// Directed stimulus for am_modulator with default parameters (CARRIER=64,
// MOD_SHIFT=0). A behavioural model predicts the registered outputs every
// cycle from the sampled inputs; a negedge process compares them. Literal
// expectations on selected samples pin the model itself.
// -----------------------------------------------------------------------------
module tb_am_modulator;

  localparam int CARRIER_M = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clkData = 1'b0;
  logic [15:0] d_in = 16'd0;
  logic        clip_clr = 1'b0;
  logic [7:0]  I_out, Q_out;
  logic        out_valid, clip;

  am_modulator dut (
    .clk       (clk),
    .reset     (reset),
    .clkData   (clkData),
    .d_in      (d_in),
    .clip_clr  (clip_clr),
    .I_out     (I_out),
    .Q_out     (Q_out),
    .out_valid (out_valid),
    .clip      (clip)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: one pending entry per detected strobe rise.
  // ---------------------------------------------------------------------------
  typedef struct {
    int cap;
    int due;
    int env;
    bit clamp;
  } pend_t;

  pend_t pend[$];
  int cyc = 0;
  int m_i = 0, m_q = 0, m_v = 0, m_clip = 0, m_phase = 0;
  bit prev_cd = 1'b1;

  always @(posedge clk) begin
    if (reset) begin
      pend.delete();
      m_i = 0; m_q = 0; m_v = 0; m_clip = 0; m_phase = 0;
      prev_cd = 1'b1;
    end else begin
      bit evt;
      evt = 1'b0;
      m_v = 0;
      foreach (pend[k]) begin
        if (pend[k].cap == cyc) begin
          logic signed [15:0] ds;
          int e;
          ds = d_in;
          e = CARRIER_M + (int'(ds) >>> 8);
          pend[k].clamp = (e < 0) || (e > 127);
          if (e < 0) e = 0;
          if (e > 127) e = 127;
          pend[k].env = e;
        end
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        case (m_phase)
          0: begin m_i =  pend[0].env; m_q = 0;            end
          1: begin m_i = 0;            m_q =  pend[0].env; end
          2: begin m_i = -pend[0].env; m_q = 0;            end
          default: begin m_i = 0;      m_q = -pend[0].env; end
        endcase
        m_v = 1;
        evt = pend[0].clamp;
        m_phase = (m_phase + 1) % 4;
        void'(pend.pop_front());
      end
      if (evt) m_clip = 1;
      else if (clip_clr) m_clip = 0;
      if (clkData && !prev_cd) pend.push_back('{cap: cyc + 2, due: cyc + 4, env: 0, clamp: 1'b0});
      prev_cd = clkData;
    end
    cyc++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cyc_valid", int'(out_valid), m_v);
      chk("cyc_I", int'($signed(I_out)), m_i);
      chk("cyc_Q", int'($signed(Q_out)), m_q);
      chk("cyc_clip", int'(clip), m_clip);
    end
  end

  // Record the most recent output pair for literal checks.
  int nvalid = 0, last_i = 0, last_q = 0, last_vcyc = 0;
  always @(negedge clk) begin
    if (out_valid) begin
      nvalid++;
      last_i = $signed(I_out);
      last_q = $signed(Q_out);
      last_vcyc = cyc;
    end
  end

  int start_cyc;

  task automatic pulse(input logic [15:0] d, input int hi);
    @(negedge clk);
    d_in = d;
    clkData = 1'b1;
    start_cyc = cyc;
    repeat (hi) @(negedge clk);
    clkData = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_check(input string name, input logic [15:0] d, input int hi,
                             input int ei, input int eq);
    int n0;
    n0 = nvalid;
    pulse(d, hi);
    chk({name, "_count"}, nvalid - n0, 1);
    chk({name, "_I"}, last_i, ei);
    chk({name, "_Q"}, last_q, eq);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_clip();
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask

  int n0;

  initial begin
    // Reset held two cycles.
    repeat (2) @(negedge clk);
    chk("rst_I", int'(I_out), 0);
    chk("rst_Q", int'(Q_out), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_clip", int'(clip), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Zero audio: carrier only, rotating through the four phases.
    pulse_check("zero_p0", 16'd0, 3, 64, 0);
    chk("latency", last_vcyc - start_cyc, 5);
    pulse_check("zero_p1", 16'd0, 3, 0, 64);
    pulse_check("zero_p2", 16'd0, 3, -64, 0);
    pulse_check("zero_p3", 16'd0, 3, 0, -64);
    pulse_check("zero_wrap", 16'd0, 3, 64, 0);

    // Positive overload clamps to 127 and sets sticky clip.
    do_reset(2);
    repeat (3) @(negedge clk);
    pulse_check("pos_clamp", 16'h7FFF, 3, 127, 0);
    chk("pos_clip", int'(clip), 1);
    pulse_check("after_clamp", 16'd0, 3, 0, 64);
    chk("clip_sticky", int'(clip), 1);
    clear_clip();
    chk("clip_cleared", int'(clip), 0);

    // Negative overload at phase 2 clamps to 0.
    pulse_check("neg_clamp", 16'h8000, 3, 0, 0);
    chk("neg_clip", int'(clip), 1);
    clear_clip();
    chk("neg_clip_cleared", int'(clip), 0);
    pulse_check("p3", 16'd0, 3, 0, -64);
    pulse_check("p0", 16'd0, 3, 64, 0);

    // Long strobe: exactly one sample, env = 64 + 10.
    pulse_check("long_hold", 16'd2560, 20, 0, 74);

    // Reset one cycle after stage-1 capture discards the sample.
    @(negedge clk);
    d_in = 16'd2560;
    clkData = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    clkData = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n0 = nvalid;
    repeat (10) @(negedge clk);
    chk("discard_count", nvalid - n0, 0);
    chk("discard_I", int'(I_out), 0);
    pulse_check("after_discard", 16'd0, 3, 64, 0);

    // Strobe already high across reset release produces nothing.
    @(negedge clk);
    clkData = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n0 = nvalid;
    repeat (10) @(negedge clk);
    chk("held_high_count", nvalid - n0, 0);
    clkData = 1'b0;
    repeat (4) @(negedge clk);
    pulse_check("after_held", 16'hFF00, 3, 63, 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/am_modulator.md
AM_MODULATOR -- requirements
Module: am_modulator

Interface
REQ-001 Parameter CARRIER, default 64, is the unmodulated envelope amplitude (0..127).
REQ-002 Parameter MOD_SHIFT, default 0, is the extra arithmetic right shift applied to audio (0..7).
REQ-003 Port clk, input, 1 bit, is the single system clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, is the synchronous, active-high reset.
REQ-005 Port clkData, input, 1 bit, is the audio sample strobe, asynchronous to clk; each rising edge marks one new sample.
REQ-006 Port d_in, input, 16 bits, is the signed two's-complement audio sample, stable from clkData rise until 3 clk cycles later.
REQ-007 Port clip_clr, input, 1 bit, clears the sticky clip flag.
REQ-008 Port I_out, output, 8 bits, is the signed in-phase sample.
REQ-009 Port Q_out, output, 8 bits, is the signed quadrature sample.
REQ-010 Port out_valid, output, 1 bit, is a one-cycle pulse marking a new I_out/Q_out pair.
REQ-011 Port clip, output, 1 bit, is the sticky envelope-clamp indicator.

Function
REQ-012 clkData SHALL pass through a 2-flop synchroniser, then a third flop for edge detection; a rising edge is sync2=1 and sync3=0.
REQ-013 Exactly one sample SHALL be processed per clkData rising edge, however long clkData stays high.
REQ-014 clkData high and low times are each at least 3 clk cycles; behaviour for shorter pulses is unspecified.
REQ-015 Stage 1: on the clk edge where the edge-detect condition is true, d_in SHALL be captured.
REQ-016 Stage 2: scaled = captured d_in >>> (8+MOD_SHIFT), arithmetic shift; env = CARRIER + scaled, computed at least 10 bits signed.
REQ-017 Stage 2 clamp: env < 0 SHALL become 0, env > 127 SHALL become 127, and either case SHALL raise a clip event.
REQ-018 Stage 3: a 2-bit phase counter SHALL select the output pair.
  - phase 0: I=env, Q=0
  - phase 1: I=0, Q=env
  - phase 2: I=-env, Q=0
  - phase 3: I=0, Q=-env
REQ-019 The phase counter SHALL increment once per output sample and wrap from 3 to 0.
REQ-020 I_out, Q_out and out_valid SHALL be registered and change only together.
REQ-021 Between pulses, I_out and Q_out SHALL hold their last values.
REQ-022 out_valid SHALL rise exactly 4 clk edges after the first clk edge at which clkData is sampled high, and SHALL stay high for 1 cycle.
REQ-023 The pipeline SHALL accept a new sample every 3 cycles with no loss.
REQ-024 clip SHALL be set on the clk edge a clamped sample reaches stage 3, and SHALL hold until cleared.
REQ-025 clip_clr SHALL clear clip on the next edge; if a clip event and clip_clr occur in the same cycle, clip SHALL remain 1.

Reset
REQ-026 While reset is high, the following SHALL be 0 on the next clk edge: I_out, Q_out, out_valid, clip, phase, the synchroniser flops and all pipeline valid bits.
REQ-027 Asserting reset mid-pipeline SHALL discard in-flight samples; no out_valid SHALL follow for them.
REQ-028 After reset deasserts, a clkData already high SHALL NOT produce a sample; only a subsequent low-to-high transition SHALL.

Verification
REQ-029 Reset is held 2 cycles -> I_out=0, Q_out=0, out_valid=0, clip=0; the first sample is output with phase 0.
REQ-030 d_in=0 with 5 clkData pulses -> (I,Q) = (64,0), (0,64), (-64,0), (0,-64), (64,0); each out_valid is 1 cycle long, 4 cycles after clkData is sampled high.
REQ-031 d_in=16'h7FFF -> env=127, I=127, clip=1; then d_in=0 -> clip remains 1; then clip_clr pulse -> clip=0.
REQ-032 d_in=16'h8000 at phase 2 -> I=0, Q=0, clip=1.
REQ-033 d_in=2560 (scaled 10) -> env=74; at phase 1, Q=74; clkData held high 20 cycles -> exactly one out_valid.
REQ-034 Reset is pulsed 1 cycle after stage-1 capture -> no out_valid follows, phase=0, and the next sample outputs (env,0).
